// File: rtl/seg_s2p_pkg.sv
// Shared definitions for the segmented serial-to-parallel receiver.
//   FRAME_BITS_DEF : default serial bits per frame
//   BIT_CNT_MAX    : saturation value of the bit counter
//   state_e        : frame state (IDLE/SHIFT/FULL/OVER)
//   cnt2state      : maps a bit count onto the frame state it implies
package seg_s2p_pkg;
  localparam int FRAME_BITS_DEF = 64;
  localparam int BIT_CNT_MAX    = 127;
  localparam int CNT_W          = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2,
    OVER  = 2'd3
  } state_e;

  function automatic state_e cnt2state(input logic [CNT_W-1:0] cnt, input int fb);
    if (cnt == '0)          return IDLE;
    else if (int'(cnt) < fb) return SHIFT;
    else if (int'(cnt) == fb) return FULL;
    else                    return OVER;
  endfunction
endpackage

// File: rtl/seg_s2p_rx_sync_ff.sv
// Multi-flop synchronizer for one asynchronous single-bit input.
//   clk   : destination clock
//   rst_n : async active-low reset, clears every stage
//   d     : asynchronous input
//   q     : synchronized output (DEPTH clk cycles of latency)
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] r_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign q = r_pipe[DEPTH-1];
endmodule

// File: rtl/seg_s2p_rx.sv
// Serial-to-parallel frame receiver. Serial bits arrive MSB-first on sout,
// qualified by the transmitter clock s_clk; a rising EN ends the frame and
// the frame is accepted only if exactly FRAME_BITS bits were shifted.
//   clk        : system clock
//   rst        : async active-low reset
//   s_clk      : serial shift clock (asynchronous to clk)
//   sout       : serial data, sampled on s_clk rise
//   EN         : frame-end strobe (rising edge)
//   s_clrn     : active-low serial clear
//   P_Data     : last good frame
//   data_valid : one-clk pulse when P_Data updates
//   frame_err  : one-clk pulse when a frame ends with the wrong bit count
//   bit_cnt    : bits shifted since last frame end/clear, saturating
module seg_s2p_rx
  import seg_s2p_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_clk,
  input  logic                  sout,
  input  logic                  EN,
  input  logic                  s_clrn,
  output logic [FRAME_BITS-1:0] P_Data,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic [CNT_W-1:0]      bit_cnt
);
  logic w_sclk_s, w_sout_s, w_en_s, w_clrn_s;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_sclk (.clk(clk), .rst_n(rst), .d(s_clk),  .q(w_sclk_s));
  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_sout (.clk(clk), .rst_n(rst), .d(sout),   .q(w_sout_s));
  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_en   (.clk(clk), .rst_n(rst), .d(EN),     .q(w_en_s));
  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_clrn (.clk(clk), .rst_n(rst), .d(s_clrn), .q(w_clrn_s));

  // Edge detect, then register the edge pulses together with the data bit
  // and clear so all frame events act on one aligned cycle. This extra
  // stage sets the SYNC_STAGES+2 result latency.
  logic r_sclk_d, r_en_d;
  logic r_shift_p, r_en_p, r_bit, r_clrn;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_d  <= 1'b0;
      r_en_d    <= 1'b0;
      r_shift_p <= 1'b0;
      r_en_p    <= 1'b0;
      r_bit     <= 1'b0;
      r_clrn    <= 1'b0;
    end else begin
      r_sclk_d  <= w_sclk_s;
      r_en_d    <= w_en_s;
      r_shift_p <= w_sclk_s & ~r_sclk_d;
      r_en_p    <= w_en_s & ~r_en_d;
      r_bit     <= w_sout_s;
      r_clrn    <= w_clrn_s;
    end
  end

  state_e                r_state, w_state_nxt, w_state_eff;
  logic [FRAME_BITS-1:0] r_shreg, w_shreg_nxt, w_shreg_eff, r_pdata;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt, w_cnt_inc, w_cnt_eff;
  logic                  r_dv, r_fe, w_load, w_err;

  // Shift is applied before the EN decision, so a coincident last bit counts.
  assign w_cnt_inc   = (r_cnt == CNT_W'(BIT_CNT_MAX)) ? r_cnt : r_cnt + 1'b1;
  assign w_cnt_eff   = r_shift_p ? w_cnt_inc : r_cnt;
  assign w_shreg_eff = r_shift_p ? {r_shreg[FRAME_BITS-2:0], r_bit} : r_shreg;
  assign w_state_eff = r_shift_p ? cnt2state(w_cnt_eff, FRAME_BITS) : r_state;

  always_comb begin
    w_state_nxt = w_state_eff;
    w_cnt_nxt   = w_cnt_eff;
    w_shreg_nxt = w_shreg_eff;
    w_load      = 1'b0;
    w_err       = 1'b0;
    if (!r_clrn) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_shreg_nxt = '0;
    end else if (r_en_p) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_shreg_nxt = '0;
      if (w_state_eff == FULL) w_load = 1'b1;
      else                     w_err  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_pdata <= '0;
      r_dv    <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_shreg_nxt;
      if (w_load) r_pdata <= w_shreg_eff;
      r_dv    <= w_load;
      r_fe    <= w_err;
    end
  end

  assign P_Data     = r_pdata;
  assign data_valid = r_dv;
  assign frame_err  = r_fe;
  assign bit_cnt    = r_cnt;
endmodule

// File: tb/tb_seg_s2p_rx.sv
module tb_seg_s2p_rx;
  localparam int FB   = 64;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          rst, s_clk, sout, EN, s_clrn;
  logic [FB-1:0] P_Data;
  logic          data_valid, frame_err;
  logic [6:0]    bit_cnt;

  seg_s2p_rx #(.FRAME_BITS(FB), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .s_clk(s_clk), .sout(sout), .EN(EN), .s_clrn(s_clrn),
    .P_Data(P_Data), .data_valid(data_valid), .frame_err(frame_err), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct { logic err; logic [63:0] data; } exp_t;
  exp_t sb[$];
  logic [63:0] last_good = '0;

  // Scoreboard: every result pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && (data_valid || frame_err)) begin
      if (sb.size() == 0) chk("sb_unexpected", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_kind", {63'b0, frame_err}, {63'b0, e.err});
        chk("sb_data", P_Data, e.data);
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk); sout = b;
    repeat (4) @(negedge clk);
    s_clk = 1'b1;
    repeat (4) @(negedge clk);
    s_clk = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] d, input int n);
    for (int i = 0; i < n; i++) send_bit(d[63 - (i % 64)]);
    repeat (4) @(negedge clk);
  endtask

  // Raise EN (optionally together with s_clk) and measure result latency.
  task automatic pulse_en(input bit with_clk);
    int n;
    @(negedge clk);
    EN = 1'b1;
    if (with_clk) s_clk = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (data_valid || frame_err) break;
    end
    chk("latency", 64'(n), 64'(SYNC + 2));
    EN = 1'b0;
    s_clk = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic push(input logic err, input logic [63:0] d);
    exp_t e;
    e.err = err; e.data = d;
    sb.push_back(e);
  endtask

  initial begin
    logic [63:0] d;
    rst = 1'b0; s_clk = 1'b0; sout = 1'b0; EN = 1'b0; s_clrn = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pdata", P_Data, 64'd0);
    chk("rst_dv",    {63'b0, data_valid}, 64'd0);
    chk("rst_fe",    {63'b0, frame_err}, 64'd0);
    chk("rst_cnt",   64'(bit_cnt), 64'd0);
    rst = 1'b1;
    repeat (6) @(negedge clk);

    // Good frame
    d = 64'hDEAD_BEEF_0123_4567;
    send_bits(d, 64);
    chk("good_cnt", 64'(bit_cnt), 64'd64);
    push(1'b0, d); last_good = d;
    pulse_en(1'b0);
    chk("good_pdata", P_Data, d);
    chk("good_cnt0",  64'(bit_cnt), 64'd0);

    // Short frame
    send_bits(64'h1234_5678_9ABC_DEF0, 63);
    chk("short_cnt", 64'(bit_cnt), 64'd63);
    push(1'b1, last_good);
    pulse_en(1'b0);
    chk("short_pdata", P_Data, last_good);

    // Long frame
    send_bits(64'hA5A5_5A5A_0F0F_F0F0, 66);
    chk("long_cnt", 64'(bit_cnt), 64'd66);
    push(1'b1, last_good);
    pulse_en(1'b0);
    chk("long_state", 64'(dut.r_state), 64'd0);
    chk("long_cnt0",  64'(bit_cnt), 64'd0);

    // Serial clear mid-frame, then a clean frame
    send_bits(64'hFFFF_0000_FFFF_0000, 30);
    chk("clr_cnt30", 64'(bit_cnt), 64'd30);
    @(negedge clk); s_clrn = 1'b0;
    repeat (6) @(negedge clk);
    chk("clr_cnt0", 64'(bit_cnt), 64'd0);
    s_clrn = 1'b1;
    repeat (6) @(negedge clk);
    d = 64'h0000_0000_FFFF_FFFF;
    send_bits(d, 64);
    push(1'b0, d); last_good = d;
    pulse_en(1'b0);
    chk("clr_pdata", P_Data, d);

    // Reset mid-frame
    send_bits(64'h5555_AAAA_5555_AAAA, 40);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("mrst_pdata", P_Data, 64'd0);
    chk("mrst_cnt",   64'(bit_cnt), 64'd0);
    chk("mrst_dvfe",  {62'b0, data_valid, frame_err}, 64'd0);
    repeat (4) @(negedge clk);
    rst = 1'b1; last_good = '0;
    repeat (6) @(negedge clk);
    chk("mrst_cnt_rel", 64'(bit_cnt), 64'd0);
    d = '1;
    send_bits(d, 64);
    push(1'b0, d); last_good = d;
    pulse_en(1'b0);
    chk("mrst_pdata2", P_Data, d);

    // 64th s_clk edge coincident with EN edge
    d = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 63; i++) send_bit(d[63-i]);
    @(negedge clk); sout = d[0];
    repeat (4) @(negedge clk);
    push(1'b0, d); last_good = d;
    pulse_en(1'b1);
    chk("coin_pdata", P_Data, d);
    chk("coin_cnt0",  64'(bit_cnt), 64'd0);

    // Counter saturation
    send_bits(64'hC3C3_3C3C_C3C3_3C3C, 130);
    chk("sat_cnt", 64'(bit_cnt), 64'd127);
    push(1'b1, last_good);
    pulse_en(1'b0);
    chk("sat_pdata", P_Data, last_good);

    repeat (10) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
